rsa_montgomery_mul: RTL and testbench
=====================================

// Module: rsa_montgomery_mul
// PURPOSE
//  Responder for the Montgomery-multiply request {a, b, modulus}: computes a*b*2^-MOD_WIDTH mod modulus.
//  Bit-serial radix-2 loop, one bit of a per clock, one final conditional subtract.
//  Sits under the RSA exponentiation engine, which issues requests and consumes KeyType results.
//  Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  MOD_WIDTH  256                 operand/modulus width (RSA_pkg::MOD_WIDTH)
//  CNT_WIDTH  $clog2(MOD_WIDTH)   iteration counter width
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  i_valid    in   1          request valid
//  i_ready    out  1          request ready
//  i_a        in   MOD_WIDTH  multiplicand a (RSAMontgomeryModIn.a), a < modulus
//  i_b        in   MOD_WIDTH  multiplier b (RSAMontgomeryModIn.b), b < modulus
//  i_modulus  in   MOD_WIDTH  modulus N (RSAMontgomeryModIn.modulus), odd, N > 1
//  o_valid    out  1          result valid
//  o_ready    in   1          result ready
//  o_data     out  MOD_WIDTH  result (RSAMontgomeryModOut)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, i_ready=1, o_valid=0, o_data=0, counter=0, accumulator=0.
//  States: IDLE -> LOOP -> FINAL -> DONE -> IDLE.
//  IDLE
//   - i_ready=1.
//   - On i_valid&&i_ready: latch a, b, N; clear R (MOD_WIDTH+2 bits); clear counter; go to LOOP.
//  LOOP (i_ready=0), once per cycle:
//   - t = R + (a[cnt] ? b : 0)
//   - t = t + (t[0] ? N : 0)
//   - R = t >> 1
//   - cnt++; after iteration cnt==MOD_WIDTH-1, go to FINAL.
//   - Exactly MOD_WIDTH iterations, LSB of a first.
//  Width rules:
//   - R < 2N is invariant, so t < 4N; intermediates are MOD_WIDTH+2 bits, no truncation.
//   - Counter never wraps within an op.
//  FINAL (one cycle): o_data <= (R >= N) ? R-N : R[MOD_WIDTH-1:0]; go to DONE.
//  DONE
//   - o_valid=1; o_data and o_valid stay stable until o_ready=1.
//   - On o_valid&&o_ready: o_valid=0, go to IDLE.
//  Latency: o_valid rises MOD_WIDTH+1 clocks after the accepting edge (257 at default). Throughput: 1 op per >= MOD_WIDTH+3 clocks.
//  Boundary conditions:
//   - i_ready=0 in LOOP/FINAL/DONE; requests are held upstream, never dropped.
//   - No same-cycle accept on the DONE->IDLE handoff; the next accept is no earlier than the following cycle.
//   - i_* changes after accept have no effect; operands are latched.
//   - a=0 or b=0 -> result 0.
//   - Reset mid-operation aborts silently: no o_valid pulse; the block returns to IDLE immediately.
//   - Even N or operands >= N: result undefined but the FSM still completes with correct latency.
// TESTING
//  1. MOD_WIDTH=8, N=13, a=1, b=1 -> o_data=3 (2^-8 mod 13); o_valid exactly 9 clocks after accept.
//  2. MOD_WIDTH=8, N=13, a=9 (R mod N), b=5 -> o_data=5; back-to-back with test 1, no stale state.
//  3. Default width, N=2^256-1, a=1, b=0x1234 -> o_data=0x1234.
//  4. Default width, N=2^256-1, a=b=N-1 -> o_data=1 (exercises final subtract).
//  5. o_ready low for 20 cycles in DONE -> o_data/o_valid stable, i_ready=0, i_valid ignored; result then consumed.
//  6. rst_n pulsed low at iteration 100 -> o_valid=0, i_ready=1 at once; next op (test 1 values) gives 3.

Source files
------------

// File: rtl/rsa_montgomery_mul.sv
// Radix-2 bit-serial Montgomery multiplier: o_data = a * b * 2^-MOD_WIDTH mod N.
// One bit of a per clock, one conditional subtract, valid/ready on both sides.
module rsa_montgomery_mul #(
    parameter int unsigned MOD_WIDTH = 256,
    parameter int unsigned CNT_WIDTH = $clog2(MOD_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_a,
    input  logic [MOD_WIDTH-1:0] i_b,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_data
);

    localparam int unsigned RW = MOD_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(MOD_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoop,
        StFinal,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [MOD_WIDTH-1:0] a_q, a_d;
    logic [MOD_WIDTH-1:0] b_q, b_d;
    logic [MOD_WIDTH-1:0] n_q, n_d;
    logic [RW-1:0]        r_q, r_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 i_ready_q, i_ready_d;
    logic                 o_valid_q, o_valid_d;
    logic [MOD_WIDTH-1:0] o_data_q, o_data_d;

    logic [RW-1:0]        t1, t2, r_next, r_sub;
    logic [MOD_WIDTH-1:0] final_res;
    logic                 unused_bits;

    // R < 2N holds every iteration, so t < 4N fits in RW bits without truncation.
    assign t1        = r_q + (a_q[cnt_q] ? {2'b00, b_q} : {RW{1'b0}});
    assign t2        = t1 + (t1[0] ? {2'b00, n_q} : {RW{1'b0}});
    assign r_next    = {1'b0, t2[RW-1:1]};
    assign r_sub     = r_q - {2'b00, n_q};
    assign final_res = (r_q >= {2'b00, n_q}) ? r_sub[MOD_WIDTH-1:0] : r_q[MOD_WIDTH-1:0];

    assign unused_bits = ^{t2[0], r_sub[RW-1:MOD_WIDTH]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        n_d       = n_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        i_ready_d = i_ready_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;

        unique case (state_q)
            StIdle: begin
                i_ready_d = 1'b1;
                if (i_valid && i_ready_q) begin
                    a_d       = i_a;
                    b_d       = i_b;
                    n_d       = i_modulus;
                    r_d       = '0;
                    cnt_d     = '0;
                    i_ready_d = 1'b0;
                    state_d   = StLoop;
                end
            end
            StLoop: begin
                r_d = r_next;
                if (cnt_q == CntLast) begin
                    state_d = StFinal;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinal: begin
                o_data_d  = final_res;
                o_valid_d = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                // i_ready rises with the move to idle, so no accept on the handoff cycle.
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    i_ready_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            n_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            n_q       <= n_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_rsa_montgomery_mul.sv
// Scoreboard bench for rsa_montgomery_mul at MOD_WIDTH=8 and the default 256.
// Expected results are queued at request time and compared when each result is consumed.
module tb_rsa_montgomery_mul;

    logic         clk;
    logic         rst_n;

    logic         i_valid8, i_ready8, o_valid8, o_ready8;
    logic [7:0]   i_a8, i_b8, i_n8, o_data8;

    logic         i_valid256, i_ready256, o_valid256, o_ready256;
    logic [255:0] i_a256, i_b256, i_n256, o_data256;

    int checks;
    int errors;

    logic [255:0] q8[$];
    logic [255:0] q256[$];

    localparam logic [255:0] NAll = {256{1'b1}};

    rsa_montgomery_mul #(
        .MOD_WIDTH(8)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid8),
        .i_ready  (i_ready8),
        .i_a      (i_a8),
        .i_b      (i_b8),
        .i_modulus(i_n8),
        .o_valid  (o_valid8),
        .o_ready  (o_ready8),
        .o_data   (o_data8)
    );

    rsa_montgomery_mul dut256 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid256),
        .i_ready  (i_ready256),
        .i_a      (i_a256),
        .i_b      (i_b256),
        .i_modulus(i_n256),
        .o_valid  (o_valid256),
        .o_ready  (o_ready256),
        .o_data   (o_data256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Brute-force x with x*2^8 == a*b (mod n); independent of the serial algorithm.
    function automatic logic [255:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] n);
        int ni;
        int target;
        ni     = int'(n);
        target = (int'(a) * int'(b)) % ni;
        for (int x = 0; x < ni; x++) begin
            if (((x * 256) % ni) == target) return 256'(x);
        end
        return '1;
    endfunction

    // With N = 2^256-1, 2^256 == 1, so the Montgomery product is a*b mod N (end-around fold).
    function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        logic [256:0] s;
        logic [255:0] r;
        p = {256'b0, a} * {256'b0, b};
        s = {1'b0, p[255:0]} + {1'b0, p[511:256]};
        r = s[255:0] + {255'b0, s[256]};
        if (r == NAll) r = '0;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (o_valid8 && o_ready8) begin
            if (q8.size() == 0) check_value("spurious8", 256'(1), 256'(0));
            else check_value("data8", 256'(o_data8), q8.pop_front());
        end
        if (o_valid256 && o_ready256) begin
            if (q256.size() == 0) check_value("spurious256", 256'(1), 256'(0));
            else check_value("data256", o_data256, q256.pop_front());
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                         input logic [255:0] exp);
        int w;
        w = 0;
        @(negedge clk);
        while (!i_ready8 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check_value("ready8_timeout", 256'(0), 256'(1));
        i_a8     = a;
        i_b8     = b;
        i_n8     = n;
        i_valid8 = 1'b1;
        @(posedge clk);
        #1;
        i_valid8 = 1'b0;
        i_a8     = 8'($urandom);
        i_b8     = 8'($urandom);
        i_n8     = 8'($urandom);
        q8.push_back(exp);
        w = 0;
        while (!o_valid8 && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_value("latency8", 256'(w), 256'(9));
    endtask

    task automatic send256(input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] exp);
        int w;
        w = 0;
        @(negedge clk);
        while (!i_ready256 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check_value("ready256_timeout", 256'(0), 256'(1));
        i_a256     = a;
        i_b256     = b;
        i_n256     = NAll;
        i_valid256 = 1'b1;
        @(posedge clk);
        #1;
        i_valid256 = 1'b0;
        i_a256     = rand256();
        i_b256     = rand256();
        i_n256     = rand256();
        q256.push_back(exp);
        w = 0;
        while (!o_valid256 && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_value("latency256", 256'(w), 256'(257));
    endtask

    initial begin
        logic [7:0]   n, a, b, cap8;
        logic [255:0] ra, rb;
        int           w;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        i_valid8   = 1'b0;
        i_a8       = '0;
        i_b8       = '0;
        i_n8       = '0;
        o_ready8   = 1'b1;
        i_valid256 = 1'b0;
        i_a256     = '0;
        i_b256     = '0;
        i_n256     = '0;
        o_ready256 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready8", 256'(i_ready8), 256'(1));
        check_value("rst_valid8", 256'(o_valid8), 256'(0));
        check_value("rst_data8", 256'(o_data8), 256'(0));
        check_value("rst_ready256", 256'(i_ready256), 256'(1));
        check_value("rst_valid256", 256'(o_valid256), 256'(0));
        check_value("rst_data256", o_data256, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 2^-8 mod 13, then a back-to-back op that must not see stale state.
        send8(8'd1, 8'd1, 8'd13, 256'(3));
        send8(8'd9, 8'd5, 8'd13, 256'(5));
        send8(8'd0, 8'd7, 8'd13, 256'(0));
        send8(8'd6, 8'd0, 8'd11, 256'(0));

        for (int i = 0; i < 6; i++) begin
            n = 8'($urandom_range(1, 127) * 2 + 1);
            a = 8'($urandom_range(0, int'(n) - 1));
            b = 8'($urandom_range(0, int'(n) - 1));
            send8(a, b, n, ref8(a, b, n));
        end

        send256(256'h1, 256'h1234, 256'h1234);
        send256(NAll - 256'd1, NAll - 256'd1, 256'd1);
        ra = rand256();
        rb = rand256();
        ra[0] = 1'b0;
        rb[0] = 1'b0;
        send256(ra, rb, ref256(ra, rb));

        // Hold the result in DONE while a new request is offered.
        o_ready8 = 1'b0;
        send8(8'd7, 8'd11, 8'd13, ref8(8'd7, 8'd11, 8'd13));
        cap8     = o_data8;
        i_valid8 = 1'b1;
        i_a8     = 8'd1;
        i_b8     = 8'd1;
        i_n8     = 8'd13;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_value("hold_valid8", 256'(o_valid8), 256'(1));
            check_value("hold_data8", 256'(o_data8), 256'(cap8));
            check_value("hold_ready8", 256'(i_ready8), 256'(0));
        end
        i_valid8 = 1'b0;
        o_ready8 = 1'b1;
        @(posedge clk);
        #1;
        check_value("drain_valid8", 256'(o_valid8), 256'(0));
        check_value("handoff_ready8", 256'(i_ready8), 256'(1));

        // Abort a 256-bit op around iteration 100 with an asynchronous reset.
        @(negedge clk);
        i_a256     = NAll - 256'd5;
        i_b256     = NAll - 256'd9;
        i_n256     = NAll;
        i_valid256 = 1'b1;
        @(posedge clk);
        #1;
        i_valid256 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_value("mid_ready256", 256'(i_ready256), 256'(0));
        rst_n = 1'b0;
        #1;
        check_value("abort_valid256", 256'(o_valid256), 256'(0));
        check_value("abort_ready256", 256'(i_ready256), 256'(1));
        check_value("abort_data256", o_data256, 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send8(8'd1, 8'd1, 8'd13, 256'(3));
        send256(256'h1, 256'h1234, 256'h1234);

        w = 0;
        while ((q8.size() != 0 || q256.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        check_value("drain_q8", 256'(q8.size()), 256'(0));
        check_value("drain_q256", 256'(q256.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
